// File: rtl/jenc_quant_pkg.sv
// Shared types for the JPEG quantizer: chroma modes, per-mode MCU geometry,
// component-of-block decode and the arithmetic width adjustments.
package jenc_quant_pkg;

  typedef enum logic [1:0] {
    CM_420 = 2'd0,
    CM_422 = 2'd1,
    CM_444 = 2'd2
  } chroma_mode_t;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  localparam logic [2:0] BPM_420 = 3'd6;
  localparam logic [2:0] BPM_422 = 3'd4;
  localparam logic [2:0] BPM_444 = 3'd3;

  localparam logic [2:0] MCU_W_LOG2_420 = 3'd4;
  localparam logic [2:0] MCU_W_LOG2_422 = 3'd4;
  localparam logic [2:0] MCU_W_LOG2_444 = 3'd3;
  localparam logic [2:0] MCU_H_LOG2_420 = 3'd4;
  localparam logic [2:0] MCU_H_LOG2_422 = 3'd3;
  localparam logic [2:0] MCU_H_LOG2_444 = 3'd3;

  // Extra product bit so the zero-extended factor multiplies as a positive signed value
  localparam int PROD_GUARD_BITS = 1;
  // Factor is Q1.(M_BITS-1): shift by M_BITS-1, half-LSB is 2^(M_BITS-2)
  localparam int FRAC_ADJ = 1;
  localparam int HALF_ADJ = 2;

  function automatic chroma_mode_t decode_mode(input logic [1:0] m);
    return (m == 2'd3) ? CM_420 : chroma_mode_t'(m);
  endfunction

  function automatic logic [2:0] blocks_per_mcu(input chroma_mode_t m);
    case (m)
      CM_422:  return BPM_422;
      CM_444:  return BPM_444;
      default: return BPM_420;
    endcase
  endfunction

  function automatic logic [2:0] mcu_w_log2(input chroma_mode_t m);
    case (m)
      CM_422:  return MCU_W_LOG2_422;
      CM_444:  return MCU_W_LOG2_444;
      default: return MCU_W_LOG2_420;
    endcase
  endfunction

  function automatic logic [2:0] mcu_h_log2(input chroma_mode_t m);
    case (m)
      CM_422:  return MCU_H_LOG2_422;
      CM_444:  return MCU_H_LOG2_444;
      default: return MCU_H_LOG2_420;
    endcase
  endfunction

  // Cr is always the last block of an MCU, Cb the one before, the rest are Y
  function automatic logic [1:0] comp_of_block(input chroma_mode_t m, input logic [2:0] blk);
    logic [2:0] n;
    n = blocks_per_mcu(m);
    if (blk == n - 3'd1)      return COMP_CR;
    else if (blk == n - 3'd2) return COMP_CB;
    else                      return COMP_Y;
  endfunction

endpackage

// File: rtl/jenc_quant_tables.sv
// Luma/chroma quantizer factor store, banked by lane so each beat reads LANES
// consecutive zigzag entries in one registered access; writes go to one entry.
module jenc_quant_tables #(
  parameter  int M_BITS = 13,
  parameter  int LANES  = 2,
  localparam int BW     = $clog2(64 / LANES)
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic                      i_sel,
  input  logic [5:0]                i_waddr,
  input  logic [M_BITS-1:0]         i_wd,
  input  logic                      i_re,
  input  logic                      i_rsel,
  input  logic [BW-1:0]             i_rbeat,
  output logic [LANES*M_BITS-1:0]   o_rd
);

  localparam int LB    = $clog2(LANES);
  localparam int DEPTH = 128 / LANES;
  localparam int IW    = 7 - LB;

  logic [6:0]    w_wfull;
  logic [IW-1:0] w_widx;
  logic [IW-1:0] w_ridx;

  assign w_wfull = {i_sel, i_waddr};
  assign w_widx  = w_wfull[6:LB];
  assign w_ridx  = {i_rsel, i_rbeat};

  for (genvar gi = 0; gi < LANES; gi++) begin : g_bank
    logic [M_BITS-1:0] r_mem [DEPTH];
    logic [M_BITS-1:0] r_rd;
    logic              w_bank_we;

    if (LANES == 1) begin : g_one
      assign w_bank_we = i_we;
    end else begin : g_many
      assign w_bank_we = i_we && (w_wfull[LB-1:0] == LB'(gi));
    end

    // Same-entry read/write in one cycle returns the old value
    always_ff @(posedge clk) begin
      if (w_bank_we) r_mem[w_widx] <= i_wd;
      if (i_re)      r_rd <= r_mem[w_ridx];
    end

    assign o_rd[gi*M_BITS +: M_BITS] = r_rd;
  end

endmodule

// File: rtl/jenc_quant_mc.sv
// JPEG quantizer: LANES coefficients per beat times a reciprocal table factor,
// rescaled and saturated, tagged with beat/component/last-MCU. Define
// JENC_QUANT_ROUND_EN for round-half-away-from-zero instead of floor.
module jenc_quant_mc
  import jenc_quant_pkg::*;
#(
  parameter  int DW            = 15,
  parameter  int QW            = 11,
  parameter  int M_BITS        = 13,
  parameter  int LANES         = 2,
  parameter  int MULT_PIPE     = 4,
  parameter  int SENSOR_X_SIZE = 1280,
  parameter  int SENSOR_Y_SIZE = 720,
  localparam int BEATS         = 64 / LANES,
  localparam int CW            = $clog2(BEATS),
  localparam int XW            = $clog2(SENSOR_X_SIZE),
  localparam int YW            = $clog2(SENSOR_Y_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES*DW-1:0]   di,
  input  logic                  di_valid,
  output logic                  di_hold,
  output logic [LANES*QW-1:0]   q,
  output logic                  q_valid,
  input  logic                  q_hold,
  output logic [CW-1:0]         q_cnt,
  output logic [1:0]            q_chroma,
  output logic                  q_last_mcu,
  input  logic [1:0]            mode,
  input  logic [XW-1:0]         x_size_m1,
  input  logic [YW-1:0]         y_size_m1,
  input  logic                  tbl_we,
  input  logic                  tbl_sel,
  input  logic [5:0]            tbl_addr,
  input  logic [M_BITS-1:0]     tbl_wd
);

  localparam int PW    = DW + M_BITS + PROD_GUARD_BITS;
  localparam int SHIFT = M_BITS - FRAC_ADJ;
  localparam logic signed [PW-1:0] QMAX = PW'((1 << (QW - 1)) - 1);
  localparam logic signed [PW-1:0] QMIN = ~QMAX;

  logic w_en;
  logic w_accept;

  assign w_en     = !q_hold;
  assign w_accept = di_valid && !q_hold;
  assign di_hold  = q_hold;

  // Position counters and the per-frame configuration shadow
  logic [CW-1:0]  r_beat;
  logic [2:0]     r_blk;
  logic [XW-1:0]  r_xmcu;
  logic [YW-1:0]  r_ymcu;
  chroma_mode_t   r_mode;
  logic [XW-1:0]  r_xm1;
  logic [YW-1:0]  r_ym1;

  logic           w_frame_start;
  chroma_mode_t   w_mode;
  logic [XW-1:0]  w_xm1;
  logic [YW-1:0]  w_ym1;
  logic [2:0]     w_bpm;
  logic [XW-1:0]  w_xlim;
  logic [YW-1:0]  w_ylim;
  logic           w_last_beat;
  logic           w_last_blk;
  logic           w_last_x;
  logic           w_last_y;
  logic [1:0]     w_comp;
  logic           w_last_mcu;

  // At frame start the shadow is not yet loaded, so the live inputs govern that beat
  assign w_frame_start = (r_beat == '0) && (r_blk == '0) && (r_xmcu == '0) && (r_ymcu == '0);
  assign w_mode        = w_frame_start ? decode_mode(mode) : r_mode;
  assign w_xm1         = w_frame_start ? x_size_m1 : r_xm1;
  assign w_ym1         = w_frame_start ? y_size_m1 : r_ym1;
  assign w_bpm         = blocks_per_mcu(w_mode);
  assign w_xlim        = w_xm1 >> mcu_w_log2(w_mode);
  assign w_ylim        = w_ym1 >> mcu_h_log2(w_mode);
  assign w_last_beat   = (r_beat == CW'(BEATS - 1));
  assign w_last_blk    = (r_blk == w_bpm - 3'd1);
  assign w_last_x      = (r_xmcu == w_xlim);
  assign w_last_y      = (r_ymcu == w_ylim);
  assign w_comp        = comp_of_block(w_mode, r_blk);
  assign w_last_mcu    = w_last_x && w_last_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat <= '0;
      r_blk  <= '0;
      r_xmcu <= '0;
      r_ymcu <= '0;
    end else if (w_accept) begin
      if (!w_last_beat) begin
        r_beat <= r_beat + CW'(1);
      end else begin
        r_beat <= '0;
        if (!w_last_blk) begin
          r_blk <= r_blk + 3'd1;
        end else begin
          r_blk <= '0;
          if (!w_last_x) begin
            r_xmcu <= r_xmcu + XW'(1);
          end else begin
            r_xmcu <= '0;
            r_ymcu <= w_last_y ? '0 : r_ymcu + YW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= CM_420;
      r_xm1  <= '0;
      r_ym1  <= '0;
    end else if (w_accept && w_frame_start) begin
      r_mode <= decode_mode(mode);
      r_xm1  <= x_size_m1;
      r_ym1  <= y_size_m1;
    end
  end

  // Input stage, aligned with the registered table read
  logic [LANES*DW-1:0]     r_di;
  logic                    r_v0;
  logic [CW-1:0]           r_cnt0;
  logic [1:0]              r_chroma0;
  logic                    r_last0;
  logic [LANES*M_BITS-1:0] w_factor;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_di      <= '0;
      r_v0      <= 1'b0;
      r_cnt0    <= '0;
      r_chroma0 <= '0;
      r_last0   <= 1'b0;
    end else if (w_en) begin
      r_di      <= di;
      r_v0      <= di_valid;
      r_cnt0    <= r_beat;
      r_chroma0 <= w_comp;
      r_last0   <= w_last_mcu;
    end
  end

  jenc_quant_tables #(
    .M_BITS (M_BITS),
    .LANES  (LANES)
  ) u_tables (
    .clk     (clk),
    .i_we    (tbl_we),
    .i_sel   (tbl_sel),
    .i_waddr (tbl_addr),
    .i_wd    (tbl_wd),
    .i_re    (w_en),
    .i_rsel  (w_comp != COMP_Y),
    .i_rbeat (r_beat),
    .o_rd    (w_factor)
  );

  // Sideband pipeline matching the multiplier depth
  logic          r_mv      [MULT_PIPE];
  logic [CW-1:0] r_mcnt    [MULT_PIPE];
  logic [1:0]    r_mchroma [MULT_PIPE];
  logic          r_mlast   [MULT_PIPE];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MULT_PIPE; i++) begin
        r_mv[i]      <= 1'b0;
        r_mcnt[i]    <= '0;
        r_mchroma[i] <= '0;
        r_mlast[i]   <= 1'b0;
      end
    end else if (w_en) begin
      r_mv[0]      <= r_v0;
      r_mcnt[0]    <= r_cnt0;
      r_mchroma[0] <= r_chroma0;
      r_mlast[0]   <= r_last0;
      for (int i = 1; i < MULT_PIPE; i++) begin
        r_mv[i]      <= r_mv[i-1];
        r_mcnt[i]    <= r_mcnt[i-1];
        r_mchroma[i] <= r_mchroma[i-1];
        r_mlast[i]   <= r_mlast[i-1];
      end
    end
  end

  logic [LANES*QW-1:0] w_q_next;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_b;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] r_p [MULT_PIPE];
    logic signed [PW-1:0] w_r;

    assign w_a    = {{(PW-DW){r_di[gi*DW+DW-1]}}, r_di[gi*DW +: DW]};
    assign w_b    = {{(PW-M_BITS){1'b0}}, w_factor[gi*M_BITS +: M_BITS]};
    assign w_prod = w_a * w_b;

    // Trailing registers give the synthesizer room to retime the multiplier
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < MULT_PIPE; i++) r_p[i] <= '0;
      end else if (w_en) begin
        r_p[0] <= w_prod;
        for (int i = 1; i < MULT_PIPE; i++) r_p[i] <= r_p[i-1];
      end
    end

`ifdef JENC_QUANT_ROUND_EN
    logic          w_neg;
    logic [PW-1:0] w_mag;
    logic [PW-1:0] w_mag_r;

    assign w_neg   = r_p[MULT_PIPE-1][PW-1];
    assign w_mag   = w_neg ? -r_p[MULT_PIPE-1] : r_p[MULT_PIPE-1];
    assign w_mag_r = (w_mag + (PW'(1) << (M_BITS - HALF_ADJ))) >> SHIFT;
    assign w_r     = w_neg ? -$signed(w_mag_r) : $signed(w_mag_r);
`else
    assign w_r = r_p[MULT_PIPE-1] >>> SHIFT;
`endif

    assign w_q_next[gi*QW +: QW] = (w_r > QMAX) ? QMAX[QW-1:0] :
                                   (w_r < QMIN) ? QMIN[QW-1:0] : w_r[QW-1:0];
  end

  logic [LANES*QW-1:0] r_q;
  logic                r_qv;
  logic [CW-1:0]       r_qcnt;
  logic [1:0]          r_qchroma;
  logic                r_qlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q       <= '0;
      r_qv      <= 1'b0;
      r_qcnt    <= '0;
      r_qchroma <= '0;
      r_qlast   <= 1'b0;
    end else if (w_en) begin
      r_q       <= w_q_next;
      r_qv      <= r_mv[MULT_PIPE-1];
      r_qcnt    <= r_mcnt[MULT_PIPE-1];
      r_qchroma <= r_mchroma[MULT_PIPE-1];
      r_qlast   <= r_mlast[MULT_PIPE-1];
    end
  end

  assign q          = r_q;
  assign q_valid    = r_qv;
  assign q_cnt      = r_qcnt;
  assign q_chroma   = r_qchroma;
  assign q_last_mcu = r_qlast;

endmodule

// File: tb/tb_jenc_quant_mc.sv
// Directed bench for jenc_quant_mc (LANES=2): reset, latency, rounding,
// saturation, subsampling modes, random stalls, mid-frame config change and reset.
module tb_jenc_quant_mc;

  localparam int DW = 15;
  localparam int QW = 11;
  localparam int MB = 13;
  localparam int LANES = 2;
  localparam int BEATS = 32;
  localparam int CW = 5;

  typedef struct packed {
    logic [QW-1:0] q1;
    logic [QW-1:0] q0;
    logic [CW-1:0] cnt;
    logic [1:0]    chroma;
    logic          last;
  } obs_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [LANES*DW-1:0]   di;
  logic                  di_valid;
  logic                  di_hold;
  logic [LANES*QW-1:0]   q;
  logic                  q_valid;
  logic                  q_hold;
  logic [CW-1:0]         q_cnt;
  logic [1:0]            q_chroma;
  logic                  q_last_mcu;
  logic [1:0]            mode;
  logic [10:0]           x_size_m1;
  logic [9:0]            y_size_m1;
  logic                  tbl_we;
  logic                  tbl_sel;
  logic [5:0]            tbl_addr;
  logic [MB-1:0]         tbl_wd;

  int checks = 0;
  int errors = 0;
  obs_t obs_q[$];

  always #5 clk = ~clk;

  jenc_quant_mc dut (
    .clk(clk), .reset(reset), .di(di), .di_valid(di_valid), .di_hold(di_hold),
    .q(q), .q_valid(q_valid), .q_hold(q_hold), .q_cnt(q_cnt), .q_chroma(q_chroma),
    .q_last_mcu(q_last_mcu), .mode(mode), .x_size_m1(x_size_m1), .y_size_m1(y_size_m1),
    .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_wd(tbl_wd)
  );

  // Output capture: a beat leaves when q_valid is high and downstream is not stalling
  always @(negedge clk) begin : cap
    obs_t o;
    if (q_valid === 1'b1 && q_hold === 1'b0) begin
      o = {q[2*QW-1:QW], q[QW-1:0], q_cnt, q_chroma, q_last_mcu};
      obs_q.push_back(o);
    end
  end

  function automatic int data_of(input int k, input int l);
    return ((k * 37 + l * 511) % 2001) - 1000;
  endfunction

  function automatic int factor_of(input int b, input int l, input int c);
    return (b * LANES + l + ((c != 0) ? 64 : 0)) * 64;
  endfunction

  function automatic int model_q(input int d, input int f);
    longint p;
    longint r;
    p = longint'(d) * longint'(f);
`ifdef JENC_QUANT_ROUND_EN
    begin
      longint m;
      m = (p < 0) ? -p : p;
      r = (m + (longint'(1) << (MB - 2))) >>> (MB - 1);
      if (p < 0) r = -r;
    end
`else
    r = p >>> (MB - 1);
`endif
    if (r > 1023) r = 1023;
    if (r < -1024) r = -1024;
    return int'(r);
  endfunction

  function automatic obs_t expect_beat(input int k, input int c, input int last);
    obs_t e;
    int b;
    b = k % BEATS;
    e.q0 = QW'(model_q(data_of(k, 0), factor_of(b, 0, c)));
    e.q1 = QW'(model_q(data_of(k, 1), factor_of(b, 1, c)));
    e.cnt = CW'(b);
    e.chroma = 2'(c);
    e.last = 1'(last);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_di(input int v0, input int v1);
    di[0 +: DW]  = DW'(v0);
    di[DW +: DW] = DW'(v1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    di_valid = 1'b0;
    q_hold = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    obs_q.delete();
  endtask

  task automatic load_const(input logic sel, input int val);
    for (int a = 0; a < 64; a++) begin
      tbl_we = 1'b1; tbl_sel = sel; tbl_addr = 6'(a); tbl_wd = MB'(val);
      tick();
    end
    tbl_we = 1'b0;
  endtask

  task automatic load_ramp();
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 64; a++) begin
        tbl_we = 1'b1; tbl_sel = 1'(s); tbl_addr = 6'(a); tbl_wd = MB'((a + 64 * s) * 64);
        tick();
      end
    end
    tbl_we = 1'b0;
  endtask

  task automatic send_one(output obs_t got, output bit to);
    di_valid = 1'b1;
    tick();
    di_valid = 1'b0;
    to = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (q_valid === 1'b1) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    got = {q[2*QW-1:QW], q[QW-1:0], q_cnt, q_chroma, q_last_mcu};
  endtask

  // Streams n beats of data_of(); optional random stalls/gaps and a config change at beat chg_at
  task automatic drive(input int n, input bit rnd, input int chg_at, input logic [1:0] m2,
                       input logic [10:0] x2, input logic [9:0] y2, output bit to);
    int k = 0;
    int cyc = 0;
    bit v;
    bit h;
    while (k < n && cyc < 4000) begin
      if (k == chg_at) begin
        mode = m2; x_size_m1 = x2; y_size_m1 = y2;
      end
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      h = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      di_valid = v;
      q_hold = h;
      set_di(data_of(k, 0), data_of(k, 1));
      if (v && !h) k++;
      tick();
      cyc++;
    end
    di_valid = 1'b0;
    q_hold = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    to = (k < n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    di_valid = 1'b0;
    q_hold = 1'b0;
    tick();
    tick();
    checks++;
    if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid got %b exp 0", q_valid); end
    checks++;
    if (q !== '0) begin errors++; $display("FAIL reset_q got %h exp 0", q); end
    checks++;
    if ({q_cnt, q_chroma, q_last_mcu} !== '0) begin
      errors++; $display("FAIL reset_sideband got cnt=%0d ch=%0d last=%b exp 0", q_cnt, q_chroma, q_last_mcu);
    end
    q_hold = 1'b1;
    #1;
    checks++;
    if (di_hold !== 1'b1) begin errors++; $display("FAIL di_hold_hi got %b exp 1", di_hold); end
    q_hold = 1'b0;
    #1;
    checks++;
    if (di_hold !== 1'b0) begin errors++; $display("FAIL di_hold_lo got %b exp 0", di_hold); end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_latency();
    obs_t got;
    obs_t exp;
    load_const(1'b0, 4096);
    do_reset();
    mode = 2'd0; x_size_m1 = 11'd15; y_size_m1 = 10'd15;
    set_di(100, -100);
    exp = {QW'(-100), QW'(100), CW'(0), 2'd0, 1'b1};
    di_valid = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      di_valid = 1'b0;
      checks++;
      if (q_valid !== (i == 6)) begin
        errors++; $display("FAIL latency_valid edge %0d got %b exp %b", i, q_valid, (i == 6));
      end
      if (i == 6) begin
        got = {q[2*QW-1:QW], q[QW-1:0], q_cnt, q_chroma, q_last_mcu};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL unity got %h exp %h", got, exp); end
      end
    end
    $display("test_latency done");
  endtask

  task automatic test_rounding();
    obs_t got;
    obs_t exp;
    bit to;
    tbl_we = 1'b1; tbl_sel = 1'b0; tbl_wd = MB'(2048);
    tbl_addr = 6'd0; tick();
    tbl_addr = 6'd1; tick();
    tbl_we = 1'b0;
    do_reset();
    set_di(3, -3);
    send_one(got, to);
`ifdef JENC_QUANT_ROUND_EN
    exp = {QW'(-2), QW'(2), CW'(0), 2'd0, 1'b1};
`else
    exp = {QW'(-2), QW'(1), CW'(0), 2'd0, 1'b1};
`endif
    checks++;
    if (to || got !== exp) begin errors++; $display("FAIL rounding timeout=%b got %h exp %h", to, got, exp); end
    $display("test_rounding done");
  endtask

  task automatic test_saturation();
    obs_t got;
    obs_t exp;
    bit to;
    tbl_we = 1'b1; tbl_sel = 1'b0; tbl_wd = MB'(8191);
    tbl_addr = 6'd0; tick();
    tbl_addr = 6'd1; tick();
    tbl_we = 1'b0;
    do_reset();
    set_di(16383, -16384);
    send_one(got, to);
    exp = {QW'(-1024), QW'(1023), CW'(0), 2'd0, 1'b1};
    checks++;
    if (to || got !== exp) begin errors++; $display("FAIL saturation timeout=%b got %h exp %h", to, got, exp); end
    $display("test_saturation done");
  endtask

  task automatic test_mode_422();
    int ch[8] = '{0, 0, 1, 2, 0, 0, 1, 2};
    obs_t exp;
    bit to;
    do_reset();
    mode = 2'd1; x_size_m1 = 11'd31; y_size_m1 = 10'd7;
    drive(256, 1'b0, -1, 2'd1, 11'd31, 10'd7, to);
    checks++;
    if (to || obs_q.size() != 256) begin
      errors++; $display("FAIL m422_count timeout=%b got %0d exp 256", to, obs_q.size());
    end
    for (int k = 0; k < 256 && k < obs_q.size(); k++) begin
      exp = expect_beat(k, ch[k / BEATS], (k / BEATS >= 4) ? 1 : 0);
      checks++;
      if (obs_q[k] !== exp) begin errors++; $display("FAIL m422 beat %0d got %h exp %h", k, obs_q[k], exp); end
    end
    $display("test_mode_422 done");
  endtask

  task automatic test_mode_444();
    int ch[6] = '{0, 1, 2, 0, 1, 2};
    obs_t exp;
    bit to;
    do_reset();
    mode = 2'd2; x_size_m1 = 11'd15; y_size_m1 = 10'd7;
    drive(192, 1'b0, -1, 2'd2, 11'd15, 10'd7, to);
    checks++;
    if (to || obs_q.size() != 192) begin
      errors++; $display("FAIL m444_count timeout=%b got %0d exp 192", to, obs_q.size());
    end
    for (int k = 0; k < 192 && k < obs_q.size(); k++) begin
      exp = expect_beat(k, ch[k / BEATS], (k / BEATS >= 3) ? 1 : 0);
      checks++;
      if (obs_q[k] !== exp) begin errors++; $display("FAIL m444 beat %0d got %h exp %h", k, obs_q[k], exp); end
    end
    $display("test_mode_444 done");
  endtask

  task automatic test_mode_change();
    int ch[9] = '{0, 0, 0, 0, 1, 2, 0, 1, 2};
    obs_t exp;
    bit to;
    do_reset();
    mode = 2'd0; x_size_m1 = 11'd15; y_size_m1 = 10'd15;
    drive(288, 1'b0, 96, 2'd2, 11'd7, 10'd7, to);
    checks++;
    if (to || obs_q.size() != 288) begin
      errors++; $display("FAIL mchg_count timeout=%b got %0d exp 288", to, obs_q.size());
    end
    for (int k = 0; k < 288 && k < obs_q.size(); k++) begin
      exp = expect_beat(k, ch[k / BEATS], 1);
      checks++;
      if (obs_q[k] !== exp) begin errors++; $display("FAIL mode_change beat %0d got %h exp %h", k, obs_q[k], exp); end
    end
    $display("test_mode_change done");
  endtask

  task automatic test_hold();
    int ch[6] = '{0, 0, 0, 0, 1, 2};
    obs_t exp;
    bit to;
    do_reset();
    mode = 2'd0; x_size_m1 = 11'd15; y_size_m1 = 10'd15;
    drive(192, 1'b1, -1, 2'd0, 11'd15, 10'd15, to);
    checks++;
    if (to || obs_q.size() != 192) begin
      errors++; $display("FAIL hold_count timeout=%b got %0d exp 192", to, obs_q.size());
    end
    for (int k = 0; k < 192 && k < obs_q.size(); k++) begin
      exp = expect_beat(k, ch[k / BEATS], 1);
      checks++;
      if (obs_q[k] !== exp) begin errors++; $display("FAIL hold beat %0d got %h exp %h", k, obs_q[k], exp); end
    end
    $display("test_hold done");
  endtask

  task automatic test_reset_mid();
    obs_t exp;
    bit to;
    do_reset();
    mode = 2'd0; x_size_m1 = 11'd31; y_size_m1 = 10'd15;
    di_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      set_di(data_of(k, 0), data_of(k, 1));
      tick();
    end
    checks++;
    if (q_valid !== 1'b1) begin errors++; $display("FAIL rmid_inflight got %b exp 1", q_valid); end
    reset = 1'b1;
    tick();
    checks++;
    if (q_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", q_valid); end
    reset = 1'b0;
    di_valid = 1'b0;
    obs_q.delete();
    mode = 2'd2; x_size_m1 = 11'd7; y_size_m1 = 10'd7;
    drive(32, 1'b0, -1, 2'd2, 11'd7, 10'd7, to);
    checks++;
    if (to || obs_q.size() != 32) begin
      errors++; $display("FAIL rmid_count timeout=%b got %0d exp 32", to, obs_q.size());
    end
    for (int k = 0; k < 32 && k < obs_q.size(); k++) begin
      exp = expect_beat(k, 0, 1);
      checks++;
      if (obs_q[k] !== exp) begin errors++; $display("FAIL reset_mid beat %0d got %h exp %h", k, obs_q[k], exp); end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    reset = 1'b1; di = '0; di_valid = 1'b0; q_hold = 1'b0;
    mode = 2'd0; x_size_m1 = 11'd15; y_size_m1 = 10'd15;
    tbl_we = 1'b0; tbl_sel = 1'b0; tbl_addr = '0; tbl_wd = '0;
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    load_ramp();
    test_mode_422();
    test_mode_444();
    test_mode_change();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
